// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and constants for the 2:1 packet-atomic stream merger.
//   state_t   : arbitration FSM states (IDLE, LOCK0, LOCK1)
//   SRC0/SRC1 : source index encodings carried on out_src
//   other_src : returns the opposite source index (round-robin hand-off)
// ---------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-way grant logic for the merger.
//   req[1:0]  : per-channel request (source valid)
//   ptr       : round-robin pointer, channel that wins a tie
//   lock_en   : a packet is in progress, only lock_id may be granted
//   lock_id   : channel that owns the current packet
//   grant[1:0]: one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2
  import mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every path starts from this default, so no latch is inferred.
    grant = 2'b00;
    if (lock_en) begin
      // Mid-packet: the owner is served only when it is actually offering.
      grant[lock_id] = req[lock_id];
    end else if (&req) begin
      grant[ptr] = 1'b1;
    end else begin
      // Zero or one requester: a lone requester never waits for ptr.
      grant = req;
    end
  end

endmodule

// File: rtl/mux2to1_arb.sv
// ---------------------------------------------------------------------------
// mux2to1_arb
// Two-input, one-output valid/ready stream merger with round-robin,
// packet-atomic arbitration and a single registered output slot.
//   clk, rst_n                     : clock, async active-low reset
//   in0_valid/data/last, in0_ready : source channel 0
//   in1_valid/data/last, in1_ready : source channel 1
//   out_valid/data/last/src        : registered output beat, src = origin
//   out_ready                      : downstream accepts the output beat
// ---------------------------------------------------------------------------
module mux2to1_arb
  import mux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready
);

  state_t        state_q;
  logic          rr_ptr_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_last_q;
  logic          out_src_q;

  logic          slot_free;
  logic [1:0]    grant;
  logic          lock_en;
  logic          lock_id;
  logic          accept0;
  logic          accept1;
  logic          accept;
  logic          acc_src;
  logic [DW-1:0] acc_data;
  logic          acc_last;

  // The slot can take a new beat if it is empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;
  assign lock_en   = (state_q != IDLE);
  assign lock_id   = (state_q == LOCK1);

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .ptr     (rr_ptr_q),
    .lock_en (lock_en),
    .lock_id (lock_id),
    .grant   (grant)
  );

  assign in0_ready = slot_free && grant[0];
  assign in1_ready = slot_free && grant[1];

  assign accept0  = in0_valid && in0_ready;
  assign accept1  = in1_valid && in1_ready;
  assign accept   = accept0 || accept1;
  assign acc_src  = accept1 ? SRC1 : SRC0;
  assign acc_data = accept1 ? in1_data : in0_data;
  assign acc_last = accept1 ? in1_last : in0_last;

  // NOTE: state is updated with non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= SRC0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= SRC0;
    end else begin
      // Output slot: a new beat wins over draining, keeping out_valid high.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_data;
        out_last_q  <= acc_last;
        out_src_q   <= acc_src;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Packet tracking: the pointer only moves on a final beat.
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (acc_last) begin
              rr_ptr_q <= other_src(acc_src);
            end else begin
              state_q <= (acc_src == SRC1) ? LOCK1 : LOCK0;
            end
          end
        end
        LOCK0, LOCK1: begin
          if (accept && acc_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= other_src(acc_src);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule
